// File: rtl/pipelined_cla_addsub.sv
// rtl/pipelined_cla_addsub.sv - pipelined carry-lookahead adder/subtractor
// One BLOCK-bit slice per stage; slice carries and skewed operands/results are registered.
`timescale 1ns/1ps
module pipelined_cla_addsub #(
   parameter int WIDTH = 64,
   parameter int BLOCK = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   input  logic             sub_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             ovf_o,
   output logic             zero_o
);

   localparam int STAGES = WIDTH / BLOCK;
   localparam int GROUPS = BLOCK / 4;

   logic             adv;
   logic [WIDTH-1:0] bx;
   logic             c0;

   // Subtraction is a + ~b + ~borrow, so only the operand and carry-in change.
   assign bx         = sub_i ? ~b_i : b_i;
   assign c0         = sub_i ^ cin_i;
   assign adv        = ~out_valid_o | out_ready_i;
   assign in_ready_o = adv;

   // Returns {carry_out, sum} for one slice built from 4-bit CLA groups.
   function automatic logic [BLOCK:0] cla_slice(input logic [BLOCK-1:0] x,
                                                input logic [BLOCK-1:0] y,
                                                input logic             ci);
      logic [BLOCK-1:0]  g;
      logic [BLOCK-1:0]  p;
      logic [BLOCK-1:0]  s;
      logic [GROUPS-1:0] gg;
      logic [GROUPS-1:0] gp;
      logic [GROUPS:0]   gc;
      logic [3:0]        c;
      g = x & y;
      p = x ^ y;
      for (int j = 0; j < GROUPS; j++) begin
         gg[j] = g[4*j+3]
               | (p[4*j+3] & g[4*j+2])
               | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
         gp[j] = &p[4*j +: 4];
      end
      gc[0] = ci;
      for (int j = 0; j < GROUPS; j++) begin
         gc[j+1] = gg[j] | (gp[j] & gc[j]);
      end
      s = '0;
      for (int j = 0; j < GROUPS; j++) begin
         c[0] = gc[j];
         c[1] = g[4*j] | (p[4*j] & c[0]);
         c[2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & c[0]);
         c[3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
              | (p[4*j+2] & p[4*j+1] & p[4*j] & c[0]);
         s[4*j +: 4] = p[4*j +: 4] ^ c;
      end
      return {gc[GROUPS], s};
   endfunction

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      localparam int W_IN = WIDTH - s * BLOCK;

      logic [W_IN-1:0]          pa;
      logic [W_IN-1:0]          pb;
      logic                     pc;
      logic                     pv;
      logic [BLOCK-1:0]         ss;
      logic                     sc;
      logic [(s+1)*BLOCK-1:0]   sum_d;
      logic [(s+1)*BLOCK-1:0]   sum_q;
      logic                     c_q;
      logic                     v_q;

      if (s == 0) begin : g_src
         assign pa    = a_i;
         assign pb    = bx;
         assign pc    = c0;
         assign pv    = in_valid_i;
         assign sum_d = ss;
      end else begin : g_src
         assign pa    = g_stage[s-1].g_fwd.a_q;
         assign pb    = g_stage[s-1].g_fwd.b_q;
         assign pc    = g_stage[s-1].c_q;
         assign pv    = g_stage[s-1].v_q;
         assign sum_d = {ss, g_stage[s-1].sum_q};
      end

      assign {sc, ss} = cla_slice(pa[BLOCK-1:0], pb[BLOCK-1:0], pc);

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            sum_q <= '0;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
         end else if (adv) begin
            sum_q <= sum_d;
            c_q   <= sc;
            v_q   <= pv;
         end
      end

      if (s < STAGES - 1) begin : g_fwd
         logic [W_IN-BLOCK-1:0] a_q;
         logic [W_IN-BLOCK-1:0] b_q;
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               a_q <= '0;
               b_q <= '0;
            end else if (adv) begin
               a_q <= pa[W_IN-1:BLOCK];
               b_q <= pb[W_IN-1:BLOCK];
            end
         end
      end else begin : g_out
         logic cmsb;
         logic ovf_q;
         logic zero_q;
         // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c.
         assign cmsb = pa[BLOCK-1] ^ pb[BLOCK-1] ^ ss[BLOCK-1];
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               ovf_q  <= 1'b0;
               zero_q <= 1'b0;
            end else if (adv) begin
               ovf_q  <= cmsb ^ sc;
               zero_q <= (sum_d == '0);
            end
         end
      end
   end

   assign out_valid_o = g_stage[STAGES-1].v_q;
   assign sum_o       = g_stage[STAGES-1].sum_q;
   assign cout_o      = g_stage[STAGES-1].c_q;
   assign ovf_o       = g_stage[STAGES-1].g_out.ovf_q;
   assign zero_o      = g_stage[STAGES-1].g_out.zero_q;

endmodule
